// File: rtl/line_feeder3_pkg.sv
// ---------------------------------------------------------------------------
// img_pkg
// Shared definitions for the line_feeder3 front end: default image geometry,
// pixel width and the fill-state encoding used by the line buffer controller.
// ---------------------------------------------------------------------------
package img_pkg;

    localparam int PIX_W_DEF      = 12;
    localparam int IMG_WIDTH_DEF  = 640;
    localparam int IMG_HEIGHT_DEF = 480;

    // FILL0/FILL1 buffer the first two lines of a frame; STREAM emits columns.
    typedef enum logic [1:0] {
        FILL0  = 2'd0,
        FILL1  = 2'd1,
        STREAM = 2'd2
    } fill_state_t;

endpackage

// File: rtl/line_feeder3_if.sv
// ---------------------------------------------------------------------------
// line_feeder3_if
// Pixel stream in / three-row column out bundle for line_feeder3.
//   pixel_in, pixel_valid, pixel_sof    : raster-order input stream
//   row0/row1/row2_pixel                : lines r-2, r-1, r at the same column
//   row2_pixel_edge                     : output column is 0 or 1
//   valid                               : single-cycle strobe, column is valid
// Modport slave is the feeder itself; master is the pixel source / consumer.
// ---------------------------------------------------------------------------
interface line_feeder3_if
    import img_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEF
) ();

    logic [PIX_W-1:0] pixel_in;
    logic             pixel_valid;
    logic             pixel_sof;
    logic [PIX_W-1:0] row0_pixel;
    logic [PIX_W-1:0] row1_pixel;
    logic [PIX_W-1:0] row2_pixel;
    logic             row2_pixel_edge;
    logic             valid;

    modport master (
        output pixel_in, pixel_valid, pixel_sof,
        input  row0_pixel, row1_pixel, row2_pixel, row2_pixel_edge, valid
    );

    modport slave (
        input  pixel_in, pixel_valid, pixel_sof,
        output row0_pixel, row1_pixel, row2_pixel, row2_pixel_edge, valid
    );

endinterface

// File: rtl/line_feeder3_line_mem.sv
// ---------------------------------------------------------------------------
// line_mem
// One image line of storage, DEPTH x WIDTH.
//   clk       : write clock
//   i_addr    : column address, shared by read and write
//   i_we      : write enable
//   i_wr_data : data written at i_addr on the rising edge
//   o_rd_data : combinational read of i_addr; returns the old contents during
//               the cycle in which the same address is written
// Contents are deliberately not reset.
// ---------------------------------------------------------------------------
module line_mem
    import img_pkg::*;
#(
    parameter int DEPTH = IMG_WIDTH_DEF,
    parameter int WIDTH = PIX_W_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic [AW-1:0]    i_addr,
    input  logic             i_we,
    input  logic [WIDTH-1:0] i_wr_data,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Asynchronous read keeps the read path aligned with pixel_in, so no
    // extra delay stage is needed for the 1-cycle output latency.
    assign o_rd_data = r_mem[i_addr];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wr_data;
        end
    end

endmodule

// File: rtl/line_feeder3.sv
// ---------------------------------------------------------------------------
// line_feeder3
// Buffers the two previous image lines and presents each accepted pixel as a
// vertically aligned column (r-2, r-1, r) one cycle later.
//   clk : rising-edge clock
//   rst : asynchronous, active-low reset
//   lf  : line_feeder3_if.slave (pixel stream in, column + valid/edge out)
// ---------------------------------------------------------------------------
module line_feeder3
    import img_pkg::*;
#(
    parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
    parameter int PIX_W      = PIX_W_DEF
) (
    input  logic          clk,
    input  logic          rst,
    line_feeder3_if.slave lf
);

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);

    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    fill_state_t      r_state;

    logic [COL_W-1:0] w_col;
    logic [ROW_W-1:0] w_row;
    fill_state_t      w_state;
    logic [COL_W-1:0] w_colNext;
    logic [ROW_W-1:0] w_rowNext;
    fill_state_t      w_stateNext;
    logic             w_endOfLine;
    logic             w_endOfFrame;

    logic [PIX_W-1:0] w_line1;
    logic [PIX_W-1:0] w_line0;

    logic [PIX_W-1:0] r_row0;
    logic [PIX_W-1:0] r_row1;
    logic [PIX_W-1:0] r_row2;
    logic             r_edge;
    logic             r_valid;

    // A start-of-frame pixel is treated as (0,0) in FILL0 regardless of the
    // current position, which also covers a mid-frame resync.
    always_comb begin
        w_col        = lf.pixel_sof ? '0 : r_col;
        w_row        = lf.pixel_sof ? '0 : r_row;
        w_state      = lf.pixel_sof ? FILL0 : r_state;
        w_endOfLine  = (w_col == COL_W'(IMG_WIDTH - 1));
        w_endOfFrame = w_endOfLine && (w_row == ROW_W'(IMG_HEIGHT - 1));

        w_colNext   = w_endOfLine ? '0 : w_col + 1'b1;
        w_rowNext   = w_row;
        w_stateNext = w_state;
        if (w_endOfLine) begin
            w_rowNext = w_endOfFrame ? '0 : w_row + 1'b1;
        end
        case (w_state)
            FILL0:   if (w_endOfLine)  w_stateNext = FILL1;
            FILL1:   if (w_endOfLine)  w_stateNext = STREAM;
            STREAM:  if (w_endOfFrame) w_stateNext = FILL0;
            default: w_stateNext = FILL0;
        endcase
    end

    // Memory 1 holds line r-1; its old data is pushed down into memory 0,
    // which then holds line r-2.
    line_mem #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W)) uMem1 (
        .clk       (clk),
        .i_addr    (w_col),
        .i_we      (lf.pixel_valid),
        .i_wr_data (lf.pixel_in),
        .o_rd_data (w_line1)
    );

    line_mem #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W)) uMem0 (
        .clk       (clk),
        .i_addr    (w_col),
        .i_we      (lf.pixel_valid),
        .i_wr_data (w_line1),
        .o_rd_data (w_line0)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_col   <= '0;
            r_row   <= '0;
            r_state <= FILL0;
        end else if (lf.pixel_valid) begin
            r_col   <= w_colNext;
            r_row   <= w_rowNext;
            r_state <= w_stateNext;
        end
    end

    // Row data holds through gaps; valid and edge drop to 0 on every cycle
    // without an accepted pixel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_row0  <= '0;
            r_row1  <= '0;
            r_row2  <= '0;
            r_edge  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= lf.pixel_valid && (w_state == STREAM);
            r_edge  <= lf.pixel_valid && (w_state == STREAM) && (w_col < COL_W'(2));
            if (lf.pixel_valid) begin
                r_row0 <= w_line0;
                r_row1 <= w_line1;
                r_row2 <= lf.pixel_in;
            end
        end
    end

    assign lf.row0_pixel      = r_row0;
    assign lf.row1_pixel      = r_row1;
    assign lf.row2_pixel      = r_row2;
    assign lf.row2_pixel_edge = r_edge;
    assign lf.valid           = r_valid;

endmodule

// File: tb/tb_line_feeder3.sv
// ---------------------------------------------------------------------------
// tb_line_feeder3
// Scoreboard bench for line_feeder3 on a 4x4 image where each pixel value is
// base + 16*row + col. The driver pushes one expected entry per clock edge;
// the monitor pops and compares on the following falling edge.
// ---------------------------------------------------------------------------
module tb_line_feeder3;
    import img_pkg::*;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int PW = 12;

    logic clk = 1'b0;
    logic rst;

    line_feeder3_if #(.PIX_W(PW)) lf ();

    line_feeder3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(PW)) dut (
        .clk (clk),
        .rst (rst),
        .lf  (lf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          v;
        logic          e;
        logic [PW-1:0] r0;
        logic [PW-1:0] r1;
        logic [PW-1:0] r2;
    } exp_t;

    exp_t expQ[$];
    int   vecCount      = 0;
    int   missCount     = 0;
    int   validSeen     = 0;
    int   validExpected = 0;

    // Compare one output cycle against its expected entry.
    task automatic checkOutput(input exp_t ex);
        bit bad;
        vecCount++;
        bad = (lf.valid !== ex.v) || (lf.row2_pixel_edge !== ex.e);
        if (ex.v && ((lf.row0_pixel !== ex.r0) || (lf.row1_pixel !== ex.r1) ||
                     (lf.row2_pixel !== ex.r2))) begin
            bad = 1'b1;
        end
        if (bad) begin
            missCount++;
            $display("[TB] FAIL column: got v=%0b e=%0b r0=%h r1=%h r2=%h, expected v=%0b e=%0b r0=%h r1=%h r2=%h",
                     lf.valid, lf.row2_pixel_edge, lf.row0_pixel, lf.row1_pixel, lf.row2_pixel,
                     ex.v, ex.e, ex.r0, ex.r1, ex.r2);
        end
    endtask

    task automatic checkZero(input string name);
        vecCount++;
        if (lf.valid !== 1'b0 || lf.row2_pixel_edge !== 1'b0 || lf.row0_pixel !== '0 ||
            lf.row1_pixel !== '0 || lf.row2_pixel !== '0) begin
            missCount++;
            $display("[TB] FAIL %s: got v=%0b e=%0b r0=%h r1=%h r2=%h, expected all zero",
                     name, lf.valid, lf.row2_pixel_edge, lf.row0_pixel, lf.row1_pixel, lf.row2_pixel);
        end
    endtask

    // Monitor: one expected entry per driven edge, popped on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (lf.valid === 1'b1) validSeen++;
            if (expQ.size() > 0) begin
                checkOutput(expQ.pop_front());
            end else if (lf.valid !== 1'b0) begin
                vecCount++;
                missCount++;
                $display("[TB] FAIL idle: got valid=%b, expected 0", lf.valid);
            end
        end
    end

    // Drive one cycle (a pixel at frame position r,c or a gap) starting from a
    // falling edge; the expected entry is pushed at the rising edge.
    task automatic applyStimulus(input int base, input int r, input int c,
                                 input bit sof, input bit gap);
        exp_t ex;
        ex = '0;
        if (gap) begin
            lf.pixel_valid = 1'b0;
            lf.pixel_sof   = 1'b0;
        end else begin
            lf.pixel_valid = 1'b1;
            lf.pixel_sof   = sof;
            lf.pixel_in    = PW'(base + 16 * r + c);
            if (r >= 2) begin
                ex.v  = 1'b1;
                ex.e  = (c < 2);
                ex.r0 = PW'(base + 16 * (r - 2) + c);
                ex.r1 = PW'(base + 16 * (r - 1) + c);
                ex.r2 = PW'(base + 16 * r + c);
                validExpected++;
            end
        end
        @(posedge clk);
        expQ.push_back(ex);
        @(negedge clk);
    endtask

    task automatic sendFrame(input int base, input bit sof, input bit gaps);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (gaps) begin
                    for (int g = 0; g < 2; g++) begin
                        if ($urandom_range(0, 1) == 1) applyStimulus(0, 0, 0, 1'b0, 1'b1);
                    end
                end
                applyStimulus(base, r, c, sof && r == 0 && c == 0, 1'b0);
            end
        end
    endtask

    initial begin
        rst            = 1'b1;
        lf.pixel_valid = 1'b0;
        lf.pixel_sof   = 1'b0;
        lf.pixel_in    = '0;
        #3 rst = 1'b0;
        #1 checkZero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;

        $display("[TB] continuous frame");
        sendFrame(0, 1'b1, 1'b0);
        $display("[TB] frame with gaps");
        sendFrame(0, 1'b1, 1'b1);
        $display("[TB] back-to-back frame without sof");
        sendFrame('h100, 1'b0, 1'b0);

        $display("[TB] resync at row 2 col 1");
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < W; c++) begin
                applyStimulus('h200, r, c, r == 0 && c == 0, 1'b0);
            end
        end
        applyStimulus('h200, 2, 0, 1'b0, 1'b0);
        sendFrame('h221, 1'b1, 1'b0);

        $display("[TB] async reset during stream");
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < W; c++) begin
                applyStimulus('h300, r, c, r == 0 && c == 0, 1'b0);
            end
        end
        applyStimulus('h300, 2, 0, 1'b0, 1'b0);
        applyStimulus('h300, 2, 1, 1'b0, 1'b0);
        #1 rst = 1'b0;
        lf.pixel_valid = 1'b0;
        #1 checkZero("async reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        sendFrame('h400, 1'b0, 1'b1);

        lf.pixel_valid = 1'b0;
        lf.pixel_sof   = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        vecCount++;
        if (expQ.size() != 0) begin
            missCount++;
            $display("[TB] FAIL drain: got %0d pending entries, expected 0", expQ.size());
        end
        vecCount++;
        if (validSeen != validExpected) begin
            missCount++;
            $display("[TB] FAIL valid count: got %0d strobes, expected %0d", validSeen, validExpected);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
